ysyx_22050039_idu_pipe: RTL

- Pipelined successor of the single-cycle decode unit: RV64I-subset decoder with an integrated GPR file, a write-back port, a per-register busy scoreboard and valid/ready handshakes on both sides.
- Sits between IFU and EXU. Stalls IFU on RAW/WAW hazards and drops the held instruction on an EXU redirect (flush).

---
 rtl/ysyx_22050039_idu_pipe.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050039_idu_pipe.sv
// ysyx_22050039_idu_pipe
// Pipelined RV64I-subset decode stage with an integrated GPR file, a
// write-back port and a per-register busy scoreboard. It sits between the
// IFU and the EXU. It stalls the IFU on RAW/WAW hazards against in-flight
// destinations, and a flush drops both the held and the incoming instruction.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        IFU handshake; in_inst, in_pc carry the instruction
//   out_valid/out_ready      EXU handshake for the decoded bundle
//   out_func                 0 INV, 1 ADDI, 2 JALR, 3 AUIPC, 4 LUI, 5 SD, 6 JAL,
//                            7 EBREAK, 8 ADD, 9 SUB, 10 BEQ, 11 BNE, 12 LD
//   out_src1/out_src2        operands (register values or immediate)
//   out_imm                  sign-extended immediate
//   out_rd                   destination register, 0 when none
//   out_pc                   PC passthrough
//   out_pc_wen               jal/jalr/branch
//   out_ebreak, out_illegal  ebreak / no pattern matched
//   wb_en, wb_rd, wb_data    register write-back, clears busy[wb_rd]
//   flush                    kill held and incoming instruction
//
// Build option
//   YSYX_22050039_IDU_BYPASS_EN  a register being written back this cycle
//   is treated as ready, and wb_data is forwarded to the operand.
module ysyx_22050039_idu_pipe #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned INST_LEN = 32,
  parameter int unsigned NR_REG   = 32,
  parameter int unsigned REG_SEL  = 5,
  parameter int unsigned FUNC_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FUNC_LEN-1:0] out_func,
  output logic [XLEN-1:0]     out_src1,
  output logic [XLEN-1:0]     out_src2,
  output logic [XLEN-1:0]     out_imm,
  output logic [REG_SEL-1:0]  out_rd,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_pc_wen,
  output logic                out_ebreak,
  output logic                out_illegal,
  input  logic                wb_en,
  input  logic [REG_SEL-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  localparam logic [FUNC_LEN-1:0] FN_INV    = FUNC_LEN'(0);
  localparam logic [FUNC_LEN-1:0] FN_ADDI   = FUNC_LEN'(1);
  localparam logic [FUNC_LEN-1:0] FN_JALR   = FUNC_LEN'(2);
  localparam logic [FUNC_LEN-1:0] FN_AUIPC  = FUNC_LEN'(3);
  localparam logic [FUNC_LEN-1:0] FN_LUI    = FUNC_LEN'(4);
  localparam logic [FUNC_LEN-1:0] FN_SD     = FUNC_LEN'(5);
  localparam logic [FUNC_LEN-1:0] FN_JAL    = FUNC_LEN'(6);
  localparam logic [FUNC_LEN-1:0] FN_EBREAK = FUNC_LEN'(7);
  localparam logic [FUNC_LEN-1:0] FN_ADD    = FUNC_LEN'(8);
  localparam logic [FUNC_LEN-1:0] FN_SUB    = FUNC_LEN'(9);
  localparam logic [FUNC_LEN-1:0] FN_BEQ    = FUNC_LEN'(10);
  localparam logic [FUNC_LEN-1:0] FN_BNE    = FUNC_LEN'(11);
  localparam logic [FUNC_LEN-1:0] FN_LD     = FUNC_LEN'(12);

  typedef enum logic [2:0] {
    FMT_N, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  logic [XLEN-1:0]   gpr [NR_REG];
  logic [NR_REG-1:0] busy;
  logic [NR_REG-1:0] busy_hz;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [REG_SEL-1:0] rs1, rs2, rd_field;

  fmt_e               fmt;
  logic [FUNC_LEN-1:0] dec_func;
  logic               dec_pc_wen;
  logic               dec_ebreak;
  logic [XLEN-1:0]    dec_imm;
  logic [XLEN-1:0]    dec_src1, dec_src2;
  logic [REG_SEL-1:0] dec_rd;
  logic               uses_rs1, uses_rs2;
  logic [XLEN-1:0]    rs1_val, rs2_val;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

  logic hazard, advance, accept;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rd_field = in_inst[11:7];
  assign rs1      = in_inst[19:15];
  assign rs2      = in_inst[24:20];

  assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec_func   = FN_INV;
    fmt        = FMT_N;
    dec_pc_wen = 1'b0;
    dec_ebreak = 1'b0;
    case (opcode)
      7'b0010011: if (funct3 == 3'b000) begin dec_func = FN_ADDI; fmt = FMT_I; end
      7'b1100111: if (funct3 == 3'b000) begin
        dec_func = FN_JALR; fmt = FMT_I; dec_pc_wen = 1'b1;
      end
      7'b0010111: begin dec_func = FN_AUIPC; fmt = FMT_U; end
      7'b0110111: begin dec_func = FN_LUI;   fmt = FMT_U; end
      7'b0100011: if (funct3 == 3'b011) begin dec_func = FN_SD; fmt = FMT_S; end
      7'b1101111: begin dec_func = FN_JAL; fmt = FMT_J; dec_pc_wen = 1'b1; end
      7'b1110011: if (in_inst == 32'h0010_0073) begin
        dec_func = FN_EBREAK; dec_ebreak = 1'b1;
      end
      7'b0110011: if (funct3 == 3'b000) begin
        if (funct7 == 7'b0000000) begin dec_func = FN_ADD; fmt = FMT_R; end
        else if (funct7 == 7'b0100000) begin dec_func = FN_SUB; fmt = FMT_R; end
      end
      7'b1100011: begin
        if (funct3 == 3'b000) begin dec_func = FN_BEQ; fmt = FMT_B; dec_pc_wen = 1'b1; end
        else if (funct3 == 3'b001) begin dec_func = FN_BNE; fmt = FMT_B; dec_pc_wen = 1'b1; end
      end
      7'b0000011: if (funct3 == 3'b011) begin dec_func = FN_LD; fmt = FMT_I; end
      default: ;
    endcase
  end

  // Register read and hazard view of busy. With the bypass, a register being
  // written back this cycle is ready and its value comes from wb_data.
  always_comb begin
    rs1_val = gpr[rs1];
    rs2_val = gpr[rs2];
    busy_hz = busy;
`ifdef YSYX_22050039_IDU_BYPASS_EN
    if (wb_en && wb_rd != '0) begin
      busy_hz[wb_rd] = 1'b0;
      if (rs1 == wb_rd) rs1_val = wb_data;
      if (rs2 == wb_rd) rs2_val = wb_data;
    end
`endif
  end

  always_comb begin
    dec_imm  = '0;
    dec_src1 = '0;
    dec_src2 = '0;
    dec_rd   = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (fmt)
      FMT_R: begin
        dec_src1 = rs1_val; dec_src2 = rs2_val; dec_rd = rd_field;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      FMT_I: begin
        dec_imm = imm_i; dec_src1 = rs1_val; dec_src2 = imm_i; dec_rd = rd_field;
        uses_rs1 = 1'b1;
      end
      FMT_S: begin
        dec_imm = imm_s; dec_src1 = rs1_val; dec_src2 = rs2_val;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      FMT_B: begin
        dec_imm = imm_b; dec_src1 = rs1_val; dec_src2 = rs2_val;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      FMT_U: begin dec_imm = imm_u; dec_src1 = imm_u; dec_rd = rd_field; end
      FMT_J: begin dec_imm = imm_j; dec_src1 = imm_j; dec_rd = rd_field; end
      default: ;
    endcase
  end

  assign hazard   = (uses_rs1 & busy_hz[rs1]) | (uses_rs2 & busy_hz[rs2]) |
                    ((dec_rd != '0) & busy_hz[dec_rd]);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr         <= '{default: '0};
      busy        <= '0;
      out_valid   <= 1'b0;
      out_func    <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_pc      <= '0;
      out_pc_wen  <= 1'b0;
      out_ebreak  <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (wb_en && wb_rd != '0) begin
        gpr[wb_rd]  <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_func    <= dec_func;
        out_src1    <= dec_src1;
        out_src2    <= dec_src2;
        out_imm     <= dec_imm;
        out_rd      <= dec_rd;
        out_pc      <= in_pc;
        out_pc_wen  <= dec_pc_wen;
        out_ebreak  <= dec_ebreak;
        out_illegal <= (dec_func == FN_INV);
        // Placed after the write-back clear so a same-cycle set wins.
        if (dec_rd != '0) busy[dec_rd] <= 1'b1;
      end else if (advance) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
